// File: rtl/somador_pkg.sv
// Shared types and elaboration helpers for the sequential add/subtract unit.
package somador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the chunk counter; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit chunk_cfg_ok(input int unsigned w, input int unsigned c);
    return (c >= 1) && (c <= w) && ((w % c) == 0);
  endfunction

endpackage

// File: rtl/somador_sequencial_param_if.sv
// Operand/result handshake bundle for somador_sequencial_param.
interface somador_sequencial_param_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, overflow, zero
  );
endinterface

// File: rtl/somador_chunk.sv
// Combinational CHUNK-bit adder slice; also exposes the carry into its top bit.
module somador_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);
  localparam int unsigned SW = CHUNK + 1;

  assign {cout, s} = {1'b0, a} + {1'b0, b} + SW'(cin);
  // Sum bit = a ^ b ^ carry_in, so the carry into the top bit is recoverable.
  assign c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];
endmodule

// File: rtl/somador_sequencial_param.sv
// Multi-cycle WIDTH-bit add/subtract: one shared CHUNK-bit slice, registered carry.
module somador_sequencial_param
  import somador_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic                       clk,
  input logic                       rst,
  somador_sequencial_param_if.slave bus
);
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = idx_w(NCHUNK);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

  if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
    $error("somador_sequencial_param: WIDTH must be a multiple of CHUNK and CHUNK in 1..WIDTH");
  end

  state_e state_q, state_d;

  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             accept_c;
  logic             last_c;
  logic [CHUNK-1:0] sl_a_c, sl_b_c, sl_s_c;
  logic             sl_cout_c, sl_cmsb_c;

  assign accept_c = bus.in_valid & in_ready_q;
  assign last_c   = (cnt_q == LAST);

  // Route the current chunk of the latched operands into the shared slice.
  always_comb begin
    sl_a_c = '0;
    sl_b_c = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (cnt_q == IDX_W'(i)) begin
        sl_a_c = a_q[i*CHUNK +: CHUNK];
        sl_b_c = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  somador_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (sl_a_c),
    .b     (sl_b_c),
    .cin   (carry_q),
    .s     (sl_s_c),
    .cout  (sl_cout_c),
    .c_msb (sl_cmsb_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = CALC;
      CALC:    if (last_c) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next-values; b is pre-inverted for subtraction.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.sub}};
          carry_d = bus.cin ^ bus.sub;
          cnt_d   = '0;
        end
      end
      CALC: begin
        for (int unsigned i = 0; i < NCHUNK; i++) begin
          if (cnt_q == IDX_W'(i)) s_d[i*CHUNK +: CHUNK] = sl_s_c;
        end
        carry_d = sl_cout_c;
        cnt_d   = cnt_q + IDX_W'(1);
        if (last_c) begin
          cnt_d  = '0;
          cout_d = sl_cout_c;
          ovf_d  = sl_cout_c ^ sl_cmsb_c;
          zero_d = (s_d == '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_somador_sequencial_param.sv
// Scoreboard bench: three configurations (8/4, 8/2, 32/8) driven from shared operand lines.
module tb_somador_sequencial_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] drv_a = '0, drv_b = '0;
  logic        drv_cin = 1'b0, drv_sub = 1'b0, drv_ordy = 1'b0;
  logic [2:0]  drv_valid = '0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        su;
  } op_t;

  exp_t exp_q[$];

  localparam int unsigned WID [3] = '{8, 8, 32};
  localparam int          LAT [3] = '{2, 4, 4};

  somador_sequencial_param_if #(.WIDTH(8))  if0 ();
  somador_sequencial_param_if #(.WIDTH(8))  if1 ();
  somador_sequencial_param_if #(.WIDTH(32)) if2 ();

  assign if0.in_valid = drv_valid[0];
  assign if0.a = drv_a[7:0];
  assign if0.b = drv_b[7:0];
  assign if0.cin = drv_cin;
  assign if0.sub = drv_sub;
  assign if0.out_ready = drv_ordy;

  assign if1.in_valid = drv_valid[1];
  assign if1.a = drv_a[7:0];
  assign if1.b = drv_b[7:0];
  assign if1.cin = drv_cin;
  assign if1.sub = drv_sub;
  assign if1.out_ready = drv_ordy;

  assign if2.in_valid = drv_valid[2];
  assign if2.a = drv_a;
  assign if2.b = drv_b;
  assign if2.cin = drv_cin;
  assign if2.sub = drv_sub;
  assign if2.out_ready = drv_ordy;

  somador_sequencial_param #(.WIDTH(8), .CHUNK(4))  u_w8c4  (.clk(clk), .rst(rst), .bus(if0.slave));
  somador_sequencial_param #(.WIDTH(8), .CHUNK(2))  u_w8c2  (.clk(clk), .rst(rst), .bus(if1.slave));
  somador_sequencial_param #(.WIDTH(32), .CHUNK(8)) u_w32c8 (.clk(clk), .rst(rst), .bus(if2.slave));

  logic [31:0] o_s [3];
  logic o_ir [3], o_ov [3], o_cout [3], o_ovf [3], o_zero [3];

  assign o_s[0] = 32'(if0.s);
  assign o_s[1] = 32'(if1.s);
  assign o_s[2] = if2.s;
  assign o_ir[0] = if0.in_ready;   assign o_ir[1] = if1.in_ready;   assign o_ir[2] = if2.in_ready;
  assign o_ov[0] = if0.out_valid;  assign o_ov[1] = if1.out_valid;  assign o_ov[2] = if2.out_valid;
  assign o_cout[0] = if0.cout;     assign o_cout[1] = if1.cout;     assign o_cout[2] = if2.cout;
  assign o_ovf[0] = if0.overflow;  assign o_ovf[1] = if1.overflow;  assign o_ovf[2] = if2.overflow;
  assign o_zero[0] = if0.zero;     assign o_zero[1] = if1.zero;     assign o_zero[2] = if2.zero;

  // Reference: signed overflow from operand/result sign bits.
  function automatic exp_t model(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic su);
    exp_t r;
    logic [31:0] mask, am, beff;
    logic [32:0] sum;
    mask   = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am     = a & mask;
    beff   = (b ^ {32{su}}) & mask;
    sum    = {1'b0, am} + {1'b0, beff} + 33'(ci ^ su);
    r.s    = sum[31:0] & mask;
    r.cout = sum[w];
    r.ovf  = (am[w-1] == beff[w-1]) && (r.s[w-1] != am[w-1]);
    r.zero = (r.s == 32'd0);
    return r;
  endfunction

  task automatic send(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                      input logic ci, input logic su);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_ir[sel] && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!o_ir[sel]) begin
      checks++;
      errors++;
      $display("FAIL send_in_ready sel=%0d got=%b exp=1", sel, o_ir[sel]);
    end
    drv_a = a; drv_b = b; drv_cin = ci; drv_sub = su;
    drv_valid[sel] = 1'b1;
    exp_q.push_back(model(WID[sel], a, b, ci, su));
    @(posedge clk);
    #1;
    drv_valid[sel] = 1'b0;
  endtask

  task automatic wait_out(input logic [1:0] sel, output int lat);
    lat = 0;
    while (!o_ov[sel] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic ack();
    @(negedge clk);
    drv_ordy = 1'b1;
    @(posedge clk);
    #1;
    drv_ordy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({o_s[i], o_cout[i], o_ovf[i], o_zero[i], o_ov[i], o_ir[i]} !== 37'd0) begin
        errors++;
        $display("FAIL reset_outputs sel=%0d got s=%h c=%b v=%b z=%b ov=%b ir=%b exp all 0",
                 i, o_s[i], o_cout[i], o_ovf[i], o_zero[i], o_ov[i], o_ir[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_ir[i] !== 1'b1 || o_ov[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_release sel=%0d got ir=%b ov=%b exp ir=1 ov=0", i, o_ir[i], o_ov[i]);
      end
    end
  endtask

  task automatic test_arith();
    op_t  tbl [8];
    exp_t e;
    int   lat;
    op_t  op;
    tbl = '{
      '{2'd0, 32'h0000_00FF, 32'h0000_0000, 1'b0, 1'b0},
      '{2'd0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0},
      '{2'd1, 32'h0000_007F, 32'h0000_0001, 1'b0, 1'b0},
      '{2'd2, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1},
      '{2'd2, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1},
      '{2'd2, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0},
      '{2'd1, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1},
      '{2'd0, 32'h0000_0080, 32'h0000_0080, 1'b0, 1'b0}
    };
    for (int i = 0; i < 14; i++) begin
      if (i < 8) op = tbl[i];
      else op = '{2'(1 + (i % 2)), $urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1))};
      send(op.sel, op.a, op.b, op.ci, op.su);
      wait_out(op.sel, lat);
      e = exp_q.pop_front();
      checks++;
      if (lat !== LAT[op.sel]) begin
        errors++;
        $display("FAIL arith_latency[%0d] got=%0d exp=%0d", i, lat, LAT[op.sel]);
      end
      checks++;
      if (o_s[op.sel] !== e.s) begin
        errors++;
        $display("FAIL arith_s[%0d] got=%h exp=%h", i, o_s[op.sel], e.s);
      end
      checks++;
      if ({o_cout[op.sel], o_ovf[op.sel], o_zero[op.sel]} !== {e.cout, e.ovf, e.zero}) begin
        errors++;
        $display("FAIL arith_flags[%0d] got c/v/z=%b%b%b exp=%b%b%b", i,
                 o_cout[op.sel], o_ovf[op.sel], o_zero[op.sel], e.cout, e.ovf, e.zero);
      end
      ack();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    send(2'd2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_out(2'd2, lat);
    e = exp_q.pop_front();
    checks++;
    if (o_s[2] !== e.s || o_cout[2] !== e.cout || o_zero[2] !== e.zero) begin
      errors++;
      $display("FAIL b2b_first got s=%h c=%b z=%b exp s=%h c=%b z=%b",
               o_s[2], o_cout[2], o_zero[2], e.s, e.cout, e.zero);
    end
    ack();
    checks++;
    if (o_ir[2] !== 1'b1 || o_ov[2] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_after_ack got ir=%b ov=%b exp ir=1 ov=0", o_ir[2], o_ov[2]);
    end
    send(2'd2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0);
    wait_out(2'd2, lat);
    e = exp_q.pop_front();
    checks++;
    if (lat !== 4 || o_s[2] !== e.s || o_ovf[2] !== e.ovf) begin
      errors++;
      $display("FAIL b2b_second got lat=%0d s=%h v=%b exp lat=4 s=%h v=%b", lat, o_s[2], o_ovf[2], e.s, e.ovf);
    end
    ack();
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   lat;
    send(2'd2, 32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b1);
    wait_out(2'd2, lat);
    e = exp_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drv_a = $urandom; drv_b = $urandom; drv_sub = 1'b0;
      drv_valid[2] = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (o_ov[2] !== 1'b1 || o_ir[2] !== 1'b0 || o_s[2] !== e.s ||
          {o_cout[2], o_ovf[2], o_zero[2]} !== {e.cout, e.ovf, e.zero}) begin
        errors++;
        $display("FAIL backpressure_hold[%0d] got ov=%b ir=%b s=%h cvz=%b%b%b exp ov=1 ir=0 s=%h cvz=%b%b%b",
                 k, o_ov[2], o_ir[2], o_s[2], o_cout[2], o_ovf[2], o_zero[2], e.s, e.cout, e.ovf, e.zero);
      end
    end
    @(negedge clk);
    drv_valid[2] = 1'b0;
    drv_ordy = 1'b1;
    @(posedge clk);
    #1;
    drv_ordy = 1'b0;
    checks++;
    if (o_ir[2] !== 1'b1 || o_ov[2] !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release got ir=%b ov=%b exp ir=1 ov=0", o_ir[2], o_ov[2]);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (o_ov[2] !== 1'b0 || o_ir[2] !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_ignored_op got ov=%b ir=%b exp ov=0 ir=1", o_ov[2], o_ir[2]);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   lat;
    send(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    void'(exp_q.pop_front());
    checks++;
    if ({o_s[2], o_cout[2], o_ovf[2], o_zero[2], o_ov[2], o_ir[2]} !== 37'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs got s=%h c=%b v=%b z=%b ov=%b ir=%b exp all 0",
               o_s[2], o_cout[2], o_ovf[2], o_zero[2], o_ov[2], o_ir[2]);
    end
    @(negedge clk);
    rst = 1'b0;
    send(2'd2, 32'd3, 32'd4, 1'b0, 1'b0);
    wait_out(2'd2, lat);
    e = exp_q.pop_front();
    checks++;
    if (lat !== 4 || o_s[2] !== e.s || o_zero[2] !== e.zero || o_cout[2] !== e.cout) begin
      errors++;
      $display("FAIL reset_mid_next_op got lat=%0d s=%h exp lat=4 s=%h", lat, o_s[2], e.s);
    end
    ack();
  endtask

  initial begin
    #1;
    test_reset();
    test_arith();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout time=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/somador_sequencial_param.md
Name: somador_sequencial_param

Overview:
- Parametrised, multi-cycle successor to the 8-bit combinational full adder.
- Adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, using one shared CHUNK-bit adder slice and a registered carry.
- Has valid/ready handshakes on both input and output, plus carry-in, subtract mode and a flag set (cout, signed overflow, zero).
- Sits as a low-area arithmetic unit beside the MIPS datapath, used wherever a full-width combinational adder is too costly.

Parameters:
- WIDTH, 32: operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 8: bits processed per cycle. 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK: derived number of compute cycles. Not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  block can accept a new operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- sub  in  1  0 = A+B+cin, 1 = A-B-cin.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- s  out  WIDTH  result.
- cout  out  1  carry out of the MSB (in sub mode: 1 means no borrow).
- overflow  out  1  two's-complement signed overflow.
- zero  out  1  s == 0.

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready=0 while rst is high, 1 from the first edge after release. s=0, cout=0, overflow=0, zero=0, out_valid=0. All internal registers are cleared.
- FSM states:
  - IDLE: in_ready=1.
  - CALC: in_ready=0.
  - DONE: out_valid=1.
- IDLE -> CALC when in_valid && in_ready at a clock edge. On that edge, latch a, b_eff = b ^ {WIDTH{sub}}, and carry register = cin ^ sub. Chunk index = 0.
- CALC: each cycle, slice i adds a[i*CHUNK +: CHUNK] + b_eff slice + carry register. It writes that slice of s and updates the carry register.
- After NCHUNK CALC cycles the FSM goes to DONE. out_valid rises exactly NCHUNK edges after the accepting edge.
  - Example: CHUNK=WIDTH gives 1-cycle latency.
- On the final slice:
  - cout = carry out.
  - overflow = carry into the MSB XOR carry out.
  - zero = (full s == 0), computed from the final registered result.
- Intermediate s bits are not guaranteed while out_valid=0. s and the flags are stable and held for the whole time out_valid=1.
- DONE -> IDLE on out_valid && out_ready. out_valid drops on the next edge.
- No pipelining. A new operation is accepted only in IDLE, so the earliest accept is the cycle after the result handshake. in_valid during CALC/DONE is ignored, and no operand register changes.
- Sub-mode semantics: A - B - cin = A + ~B + (1 - cin). Hence the effective carry-in is cin ^ sub.
- Arithmetic is modulo 2^WIDTH. Wrap-around is reported only through cout and overflow.
- rst asserted mid-CALC or mid-DONE: abort immediately (async). The result is discarded and reset values apply.
- out_ready high while out_valid=0 has no effect.

Decomposition:
- Package somador_pkg:
  - state enum {IDLE, CALC, DONE}.
  - function clog2-based index width for the chunk counter.
  - elaboration-time check that WIDTH % CHUNK == 0.
- Sub-module somador_chunk (combinational, CHUNK param).
  - Inputs: a, b, cin.
  - Outputs: s, cout, c_msb (carry into the top bit of the slice).
  - Instantiated once; the top level muxes slices into it by chunk index.

Test Plan:
- WIDTH=8, CHUNK=4:
  - a=FF, b=00, cin=0, sub=0 -> s=FF, cout=0, ovf=0, zero=0.
  - out_valid rises 2 edges after accept.
- WIDTH=8, CHUNK=4, a=FF, b=01, sub=0 -> s=00, cout=1, ovf=0, zero=1.
- WIDTH=8, CHUNK=2, a=7F, b=01, sub=0 -> s=80, cout=0, ovf=1, zero=0. Latency is 4.
- WIDTH=32, CHUNK=8, sub=1:
  - a=5, b=7, cin=0 -> s=FFFFFFFE, cout=0, ovf=0.
  - a=80000000, b=1 -> s=7FFFFFFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles -> s and flags are stable, in_ready=0, and a new in_valid is ignored. Then out_ready=1 -> in_ready=1 on the next cycle.
- Assert rst in the 2nd CALC cycle -> all outputs are 0 at once. After release, the next operation a=3, b=4 gives s=7.
